ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_pkg.sv | 31 +++
 rtl/ex_stage_mul_div_unit.sv | 112 +++++++++++
 rtl/ex_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, mul/div FSM states and default width.
package ex_pkg;

    localparam int W_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLL   = 4'd6,
        OP_SRL   = 4'd7,
        OP_MFHI  = 4'd8,
        OP_MFLO  = 4'd9,
        OP_MULTU = 4'd10,
        OP_DIVU  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_mul_div(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_stage_mul_div_unit.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle, with HI/LO result registers.
//   state   | meaning
//   MD_IDLE | waiting for start; operands latched on the start edge
//   MD_BUSY | W iterations, counter runs W-1 down to 0
//   MD_DONE | result ready; HI/LO written on the edge leaving this state
module mul_div_unit
    import ex_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         stall,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(W) + 1;

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          div_q;
    logic [W-1:0]  mcand_q;
    logic [W-1:0]  acc_hi_q, acc_lo_q;
    logic [W-1:0]  nxt_hi, nxt_lo;
    logic [W:0]    sum, shifted, diff;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start)          state_d = MD_BUSY;
            MD_BUSY: if (cnt_q == '0)    state_d = MD_DONE;
            MD_DONE: if (!stall)         state_d = MD_IDLE;
            default:                     state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
        shifted = {acc_hi_q, acc_lo_q[W-1]};
        diff    = shifted - {1'b0, mcand_q};
        nxt_hi  = '0;
        nxt_lo  = '0;
        if (div_q) begin
            // Divide by zero falls out naturally: every step subtracts 0, giving all-ones / A.
            if (shifted >= {1'b0, mcand_q}) begin
                nxt_hi = diff[W-1:0];
                nxt_lo = {acc_lo_q[W-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[W-1:0];
                nxt_lo = {acc_lo_q[W-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum[W:1];
            nxt_lo = {sum[0], acc_lo_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            div_q    <= 1'b0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        div_q    <= is_div;
                        mcand_q  <= is_div ? b : a;
                        acc_lo_q <= is_div ? a : b;
                        acc_hi_q <= '0;
                        cnt_q    <= CW'(W - 1);
                    end
                end
                MD_BUSY: begin
                    acc_hi_q <= nxt_hi;
                    acc_lo_q <= nxt_lo;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                MD_DONE: begin
                    if (!stall) begin
                        hi <= acc_hi_q;
                        lo <= acc_lo_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == MD_BUSY);
    assign done = (state_q == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative mul/div and the EX/MEM register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         id_valid,
    input  logic [3:0]   id_alu_op,
    input  logic [W-1:0] id_rs_val,
    input  logic [W-1:0] id_rt_val,
    input  logic [W-1:0] id_imm,
    input  logic         id_alu_src,
    input  logic [4:0]   id_rd,
    input  logic         id_wb,
    input  logic         id_mem_read,
    input  logic         id_mem_write,
    input  logic [1:0]   ForwardA,
    input  logic [1:0]   ForwardB,
    input  logic [W-1:0] mem_wb_data,
    input  logic         mem_stall,
    output logic         ex_hold,
    output logic         exmem_valid,
    output logic         exmem_wb,
    output logic         exmem_mem_read,
    output logic         exmem_mem_write,
    output logic [4:0]   exmem_rd,
    output logic [W-1:0] exmem_alu,
    output logic [W-1:0] exmem_store
);

    logic [W-1:0] op_a, rt_fwd, op_b, alu_result;
    logic [W-1:0] md_hi, md_lo;
    logic         md_op, md_busy, md_done, md_start;

    always_comb begin
        case (ForwardA)
            2'b10:   op_a = exmem_alu;
            2'b01:   op_a = mem_wb_data;
            default: op_a = id_rs_val;
        endcase
        case (ForwardB)
            2'b10:   rt_fwd = exmem_alu;
            2'b01:   rt_fwd = mem_wb_data;
            default: rt_fwd = id_rt_val;
        endcase
        op_b = id_alu_src ? id_imm : rt_fwd;
    end

    always_comb begin
        alu_result = '0;
        case (alu_op_e'(id_alu_op))
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_SLT:  alu_result = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL:  alu_result = op_b << op_a[4:0];
            OP_SRL:  alu_result = op_b >> op_a[4:0];
            OP_MFHI: alu_result = md_hi;
            OP_MFLO: alu_result = md_lo;
            default: alu_result = '0;
        endcase
    end

    assign md_op    = is_mul_div(id_alu_op);
    assign md_start = id_valid && md_op && !md_busy && !md_done;
    assign ex_hold  = mem_stall || (id_valid && md_op && !md_done);

    mul_div_unit #(.W(W)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (id_alu_op == OP_DIVU),
        .a      (op_a),
        .b      (op_b),
        .stall  (mem_stall),
        .busy   (md_busy),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    // A mul/div in flight loads bubbles until its DONE cycle, then retires with no writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_valid     <= 1'b0;
            exmem_wb        <= 1'b0;
            exmem_mem_read  <= 1'b0;
            exmem_mem_write <= 1'b0;
            exmem_rd        <= '0;
            exmem_alu       <= '0;
            exmem_store     <= '0;
        end else if (!mem_stall) begin
            exmem_rd    <= id_rd;
            exmem_alu   <= alu_result;
            exmem_store <= rt_fwd;
            if (id_valid && md_op) begin
                exmem_valid     <= md_done;
                exmem_wb        <= 1'b0;
                exmem_mem_read  <= 1'b0;
                exmem_mem_write <= 1'b0;
            end else begin
                exmem_valid     <= id_valid;
                exmem_wb        <= id_valid && id_wb;
                exmem_mem_read  <= id_valid && id_mem_read;
                exmem_mem_write <= id_valid && id_mem_write;
            end
        end
    end

endmodule
